// File: rtl/brew_sequencer.sv
// Coffee-maker brew sequencer: drives the seconds timer through HEAT, BREW and MILK phases.
// Optional phase watchdog enabled by defining BREW_WATCHDOG_EN.
module brew_sequencer #(
   parameter logic [1:0] HEAT_SECS = 2'd3,
   parameter logic [1:0] BREW_SECS = 2'd2,
   parameter logic [1:0] MILK_SECS = 2'd1
`ifdef BREW_WATCHDOG_EN
   ,parameter int unsigned WDOG_CYCLES = 400000000
`endif
) (
   input  logic       clk_100MHz,
   input  logic       reset,
   input  logic       start,
   input  logic       cancel,
   input  logic [1:0] drink,
   input  logic       t_expired,
   output logic       start_timer,
   output logic [1:0] value,
   output logic       heater,
   output logic       pump,
   output logic       milk_valve,
   output logic       busy,
   output logic       done,
   output logic       fault,
   output logic [2:0] step
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HEAT    = 3'd1,
      BREW    = 3'd2,
      MILK    = 3'd3,
      RELEASE = 3'd4,
      DONE    = 3'd5,
      FAULT   = 3'd6
   } state_t;

   state_t     state_q, state_d;
   state_t     next_q, next_d;
   logic [1:0] drink_q, drink_d;
   logic [1:0] brew_cnt_q, brew_cnt_d;
   logic [1:0] brew_inc;
   logic       start_timer_q, start_timer_d;
   logic [1:0] value_q, value_d;
   logic       heater_q, heater_d;
   logic       pump_q, pump_d;
   logic       milk_valve_q, milk_valve_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       fault_q, fault_d;
   logic       wdog_hit;

`ifdef BREW_WATCHDOG_EN
   localparam logic [28:0] WDOG_LAST = 29'(WDOG_CYCLES - 1);
   logic [28:0] wdog_cnt_q, wdog_cnt_d;

   // Counter restarts whenever the state changes, so it measures time spent in the current state.
   always_comb begin
      wdog_cnt_d = wdog_cnt_q + 29'd1;
      if (state_d != state_q) begin
         wdog_cnt_d = 29'd0;
      end else begin
         wdog_cnt_d = wdog_cnt_q + 29'd1;
      end
   end

   assign wdog_hit = (wdog_cnt_q == WDOG_LAST) &&
                     ((state_q == HEAT) || (state_q == BREW) ||
                      (state_q == MILK) || (state_q == RELEASE));

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         wdog_cnt_q <= 29'd0;
      end else begin
         wdog_cnt_q <= wdog_cnt_d;
      end
   end
`else
   assign wdog_hit = 1'b0;
`endif

   assign brew_inc = brew_cnt_q + 2'd1;

   // Next-state logic; cancel takes priority over phase exit.
   always_comb begin
      state_d    = state_q;
      next_d     = next_q;
      drink_d    = drink_q;
      brew_cnt_d = brew_cnt_q;
      case (state_q)
         IDLE: begin
            if (start && !cancel && (drink != 2'd3)) begin
               state_d    = HEAT;
               drink_d    = drink;
               brew_cnt_d = 2'd0;
            end else begin
               state_d = IDLE;
            end
         end
         HEAT, MILK: begin
            if (cancel) begin
               state_d = RELEASE;
               next_d  = IDLE;
            end else if (t_expired) begin
               state_d = RELEASE;
               next_d  = (state_q == HEAT) ? BREW : DONE;
            end else begin
               state_d = state_q;
            end
         end
         BREW: begin
            if (cancel) begin
               state_d = RELEASE;
               next_d  = IDLE;
            end else if (t_expired) begin
               state_d    = RELEASE;
               brew_cnt_d = brew_inc;
               case (drink_q)
                  2'd1:    next_d = MILK;
                  2'd2:    next_d = (brew_inc >= 2'd2) ? DONE : BREW;
                  default: next_d = DONE;
               endcase
            end else begin
               state_d = BREW;
            end
         end
         RELEASE: begin
            if (cancel) begin
               next_d = IDLE;
            end else begin
               next_d = next_q;
            end
            if (!t_expired) begin
               state_d = cancel ? IDLE : next_q;
            end else begin
               state_d = RELEASE;
            end
         end
         DONE:    state_d = IDLE;
         FAULT:   state_d = FAULT;
         default: state_d = IDLE;
      endcase
      state_d = wdog_hit ? FAULT : state_d;
   end

   // Outputs decoded from the upcoming state so they line up with state_q.
   always_comb begin
      start_timer_d = (state_d == HEAT) || (state_d == BREW) || (state_d == MILK);
      heater_d      = (state_d == HEAT) || (state_d == BREW);
      pump_d        = (state_d == BREW);
      milk_valve_d  = (state_d == MILK);
      busy_d        = (state_d != IDLE);
      done_d        = (state_d == DONE);
      fault_d       = (state_d == FAULT);
      case (state_d)
         HEAT:    value_d = HEAT_SECS;
         BREW:    value_d = BREW_SECS;
         MILK:    value_d = MILK_SECS;
         FAULT:   value_d = 2'd0;
         default: value_d = value_q;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         state_q       <= IDLE;
         next_q        <= IDLE;
         drink_q       <= 2'd0;
         brew_cnt_q    <= 2'd0;
         start_timer_q <= 1'b0;
         value_q       <= 2'd0;
         heater_q      <= 1'b0;
         pump_q        <= 1'b0;
         milk_valve_q  <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         next_q        <= next_d;
         drink_q       <= drink_d;
         brew_cnt_q    <= brew_cnt_d;
         start_timer_q <= start_timer_d;
         value_q       <= value_d;
         heater_q      <= heater_d;
         pump_q        <= pump_d;
         milk_valve_q  <= milk_valve_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         fault_q       <= fault_d;
      end
   end

   assign start_timer = start_timer_q;
   assign value       = value_q;
   assign heater      = heater_q;
   assign pump        = pump_q;
   assign milk_valve  = milk_valve_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign fault       = fault_q;
   assign step        = state_q;

endmodule

// File: doc/brew_sequencer.md
Name: brew_sequencer

Overview:
- Upstream controller for the seconds timer (temporizador) in the coffee maker.
- Accepts a drink selection and start/cancel requests, then steps through HEAT, BREW and optional MILK phases.
- For each phase it drives the timer's start_timer/value interface and the actuator enables, and waits on t_expired.
- Emits a one-cycle done pulse at the end of the sequence.

Parameters:
- HEAT_SECS, 2'd3, timer value for the heat phase
- BREW_SECS, 2'd2, timer value for each brew phase
- MILK_SECS, 2'd1, timer value for the milk phase
- WDOG_CYCLES, 400000000, clk cycles allowed per phase before a fault (used only with the optional feature)

Ports:
- clk_100MHz  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  start request; level, acted on only in IDLE
- cancel  in  1  abort request; level
- drink  in  2  0=espresso, 1=latte, 2=double, 3=invalid
- t_expired  in  1  from timer
- start_timer  out  1  to timer; held high for the whole phase
- value  out  2  to timer; phase duration in seconds
- heater  out  1  heater enable
- pump  out  1  pump enable
- milk_valve  out  1  milk valve enable
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when a sequence completes
- fault  out  1  watchdog fault flag; constant 0 without the optional feature
- step  out  3  state code: IDLE=0, HEAT=1, BREW=2, MILK=3, RELEASE=4, DONE=5, FAULT=6

Behaviour:
- Reset (synchronous, active-high)
  - State becomes IDLE; all outputs 0; value=0.
  - Latched drink and brew count cleared.
  - Reset overrides every other input on the same edge.
- All outputs are registered and decoded from the state and latched registers; no combinational path from input to output.
- IDLE
  - start=1, cancel=0 and drink!=3: latch drink, clear brew_cnt, go to HEAT on the next edge.
  - drink=3: the request is ignored and the block stays in IDLE.
- HEAT: start_timer=1, value=HEAT_SECS, heater=1.
- BREW: start_timer=1, value=BREW_SECS, heater=1, pump=1.
- MILK: start_timer=1, value=MILK_SECS, milk_valve=1.
- Phase exit
  - In HEAT, BREW or MILK, sampling t_expired=1 selects the next phase and enters RELEASE.
  - Next phase after HEAT is BREW.
  - After BREW:
    - espresso: DONE
    - latte: MILK
    - double: BREW again, then DONE once brew_cnt reaches 2
  - brew_cnt increments on each BREW exit.
  - After MILK: DONE.
- RELEASE
  - start_timer=0, actuators 0, value holds its last value.
  - Stay at least one cycle.
  - Leave only when t_expired samples 0: go to the next phase, or to IDLE if the sequence was cancelled.
  - This handshake guarantees the timer has seen start_timer fall and cleared before it is re-armed.
- DONE: done=1 for exactly one cycle, then IDLE.
- Cancel
  - Priority over phase exit in HEAT, BREW and MILK: if cancel=1, enter RELEASE with next=IDLE even when t_expired=1 in the same cycle.
  - Cancel in RELEASE forces next=IDLE.
  - Cancel is ignored in IDLE, DONE and FAULT.
- start while busy is ignored. A held start re-triggers only after returning to IDLE.
- Zero duration: a value of 0 is legal. The phase lasts until the timer's first expiry, typically 2–3 cycles.
- drink is sampled only in IDLE. Changes mid-sequence have no effect.

Optional Feature:
- Macro: BREW_WATCHDOG_EN.
- When defined:
  - A 29-bit cycle counter clears on entry to each of HEAT, BREW, MILK and RELEASE.
  - If the counter reaches WDOG_CYCLES while still in that state, go to FAULT.
  - FAULT: all outputs 0 except fault=1 and busy=1.
  - FAULT is left only by reset. cancel and start have no effect.
- When undefined: no counter, FAULT is unreachable, fault is tied to 0.

Test Plan:
- Espresso: reset, then drink=0, start pulse. Timer model expires 5 cycles after start_timer rises.
  - Required step sequence: 1,4,2,4,5,0; done pulses once.
  - value=3 during HEAT and 2 during BREW; pump=1 only in BREW; milk_valve never 1.
- Latte and double:
  - drink=1: MILK entered after BREW with value=1, milk_valve=1.
  - drink=2: BREW entered twice, with RELEASE between; done after the second BREW.
- Release handshake: the model keeps t_expired=1 for 4 cycles after start_timer falls.
  - RELEASE lasts ≥4 cycles; start_timer stays 0 until t_expired=0.
- Cancel with simultaneous expiry: cancel=1 in the same cycle t_expired=1 during BREW.
  - Next state is RELEASE, then IDLE; no done pulse; pump=0 from the next cycle.
- Invalid and reset:
  - drink=3 with start: stays in IDLE, busy=0.
  - reset asserted mid-HEAT: the next edge gives step=0 and all outputs 0.
- Watchdog (BREW_WATCHDOG_EN, WDOG_CYCLES=20): the model never asserts t_expired.
  - At cycle 20 of HEAT: fault=1, heater=0, start_timer=0.
  - Stays in FAULT despite cancel; cleared only by reset.
